serial_subtractor: RTL and testbench

- Bit-serial unsigned/two's-complement subtractor computing `a - b`; the subtract counterpart to the team's XOR/AND half-adder cell.
- Datapath is one full-subtractor cell (XOR difference, borrow logic) plus a borrow flip-flop, processing operands LSB-first, one bit per clock.
- Start/ready/done handshake; used wherever area matters more than latency.

---
 rtl/serial_subtractor.sv | 132 +++++++++++++
 tb/tb_serial_subtractor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB-first through one full-subtractor
// cell and a borrow flop, with a start/ready/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_bin;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_borrow;
    logic             r_ovf;

    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    assign w_a0       = r_a[0];
    assign w_b0       = r_b[0];
    assign w_d        = w_a0 ^ w_b0 ^ r_bin;
    assign w_bout     = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_bin);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_bin    <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_res   <= '0;
                        r_bin   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_bin <= w_bout;
                    r_cnt <= r_cnt + CW'(1);
                    // On the final bit w_d is the result MSB, so publish straight from the cell.
                    if (w_last) begin
                        r_diff   <= w_res_next;
                        r_borrow <= w_bout;
                        r_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff     = r_diff;
    assign borrow   = r_borrow;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): latency, results, flags,
// ignored start, mid-op reset and back-to-back ops with start held high.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] cur_diff;
    logic       cur_borrow;
    logic       cur_ovf;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_held(input string tag);
        chk({tag, ".diff"}, {24'd0, diff}, {24'd0, cur_diff});
        chk({tag, ".borrow"}, {31'd0, borrow}, {31'd0, cur_borrow});
        chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, cur_ovf});
    endtask

    // Issues one op; start is accepted on the first edge. Optionally pokes a
    // junk start mid-SHIFT. Returns with the block back in IDLE.
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] ed, input logic eb, input logic eo,
                          input bit inject);
        a = va;
        b = vb;
        start = 1'b1;
        step();
        start = 1'b0;
        a = ~va;
        b = ~vb;
        chk({tag, ".busy"}, {31'd0, ready}, 32'd0);
        for (int i = 1; i <= 7; i++) begin
            if (inject && i == 3) begin
                a = 8'hAA;
                b = 8'h11;
                start = 1'b1;
            end
            step();
            start = 1'b0;
            chk({tag, ".nodone"}, {31'd0, done}, 32'd0);
            chk({tag, ".ready_lo"}, {31'd0, ready}, 32'd0);
            chk_held({tag, ".hold"});
        end
        step();
        cur_diff   = ed;
        cur_borrow = eb;
        cur_ovf    = eo;
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".ready_done"}, {31'd0, ready}, 32'd0);
        chk_held({tag, ".res"});
        step();
        chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, ".ready_back"}, {31'd0, ready}, 32'd1);
        chk_held({tag, ".after"});
    endtask

    logic [7:0] h_a [3];
    logic [7:0] h_b [3];
    logic [7:0] h_d [3];
    logic       h_bo[3];
    logic       h_ov[3];

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h5A;
        b     = 8'h33;
        cur_diff   = 8'h00;
        cur_borrow = 1'b0;
        cur_ovf    = 1'b0;
        step();
        step();
        chk("reset.ready", {31'd0, ready}, 32'd1);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk_held("reset");
        rst   = 1'b0;
        start = 1'b0;
        step();
        chk("idle.ready", {31'd0, ready}, 32'd1);

        run_op("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
        step();
        chk("idle_after1.done", {31'd0, done}, 32'd0);
        run_op("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
        run_op("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op("sub_7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);

        run_op("ignored_start", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("ignored.no_second_done", {31'd0, done}, 32'd0);
            chk("ignored.idle", {31'd0, ready}, 32'd1);
        end

        run_op("sub_7F_FF_again", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        cur_diff   = 8'h00;
        cur_borrow = 1'b0;
        cur_ovf    = 1'b0;
        chk("midrst.ready", {31'd0, ready}, 32'd1);
        chk("midrst.done", {31'd0, done}, 32'd0);
        chk_held("midrst");
        for (int i = 0; i < 8; i++) begin
            step();
            chk("midrst.no_done", {31'd0, done}, 32'd0);
        end
        run_op("sub_10_01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);

        // Start held high: accepted every 10 cycles with fresh operands.
        h_a[0] = 8'h20; h_b[0] = 8'h0F; h_d[0] = 8'h11; h_bo[0] = 1'b0; h_ov[0] = 1'b0;
        h_a[1] = 8'h0F; h_b[1] = 8'h20; h_d[1] = 8'hEF; h_bo[1] = 1'b1; h_ov[1] = 1'b0;
        h_a[2] = 8'h64; h_b[2] = 8'h9C; h_d[2] = 8'hC8; h_bo[2] = 1'b1; h_ov[2] = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = h_a[k];
            b = h_b[k];
            step();
            chk("held.accepted", {31'd0, ready}, 32'd0);
            if (k < 2) begin
                a = h_a[k+1];
                b = h_b[k+1];
            end
            for (int i = 1; i <= 7; i++) begin
                step();
                chk("held.nodone", {31'd0, done}, 32'd0);
                chk_held("held.stable");
            end
            step();
            cur_diff   = h_d[k];
            cur_borrow = h_bo[k];
            cur_ovf    = h_ov[k];
            chk("held.done", {31'd0, done}, 32'd1);
            chk_held("held.res");
            step();
            chk("held.done_pulse", {31'd0, done}, 32'd0);
            chk("held.ready", {31'd0, ready}, 32'd1);
            chk_held("held.after");
        end
        start = 1'b0;
        step();
        chk("final.idle", {31'd0, ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
